// File: rtl/down_sched_pkg.sv
// Shared types and helpers for the down-counter scheduler.
// Contents: state enum, default sizes, round-robin first-set search.
package down_sched_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 4;

    // The search works on a fixed 8-bit vector so one function serves every NREQ.
    localparam int unsigned RR_MAX   = 8;
    localparam int unsigned RR_PTR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // First set bit of req at or above ptr, wrapping modulo n.
    function automatic logic [RR_PTR_W-1:0] rr_first(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_PTR_W-1:0] ptr,
        input int unsigned         n
    );
        logic [RR_PTR_W-1:0] win;
        logic                found;
        int unsigned         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[RR_PTR_W-1:0]]) begin
                win   = idx[RR_PTR_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/down_load_counter.sv
// Loadable down counter that saturates at zero.
// Ports: clk, rst (async, active-high), load (loads load_val, wins over en),
//        en (decrement), q (current value).
module down_load_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: load, saturating decrement, or hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en && (q_q != '0)) begin
            q_d = q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/down_timer_sched.sv
// Round-robin scheduler sharing one down counter among NREQ requesters.
// Ports: clk, rst (async, active-high), req (per-requester level),
//        load_val (per-requester countdown, slice i*WIDTH +: WIDTH),
//        grant (one-hot owner), busy (owned), count (counter value),
//        done (one-cycle completion pulse to the owner).
module down_timer_sched
    import down_sched_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int unsigned PTR_W = RR_PTR_W;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic [PTR_W-1:0]  win;
    logic [WIDTH-1:0]  sel_val;
    logic [WIDTH-1:0]  cnt_q;
    logic              cnt_load;
    logic              cnt_en;
    logic [RR_MAX-1:0] req_ext;
    logic              any_req;
    logic              owner_req;
    logic              cnt_zero;

    assign req_ext   = RR_MAX'(req);
    assign any_req   = (req != '0);
    assign owner_req = req_ext[owner_q];
    assign cnt_zero  = (cnt_q == '0);
    assign win       = rr_first(req_ext, ptr_q, NREQ);

    // Countdown value of the arbitration winner.
    always_comb begin
        sel_val = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == PTR_W'(i)) begin
                sel_val = load_val[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abandonment takes priority over reaching zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = COUNT;
            COUNT: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath control; results are registered below.
    always_comb begin
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = (state_d != IDLE);
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d  = NREQ'(1) << win;
                    owner_d  = win;
                    ptr_d    = PTR_W'((32'(win) + 32'd1) % NREQ);
                    cnt_load = 1'b1;
                end
            end
            COUNT: begin
                if (!owner_req) begin
                    grant_d = '0;
                end else if (cnt_zero) begin
                    done_d = NREQ'(1) << owner_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE:    grant_d = '0;
            default: grant_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    down_load_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (sel_val),
        .en       (cnt_en),
        .q        (cnt_q)
    );

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_down_timer_sched.sv
// Bench for down_timer_sched: vector table driven on falling edges, expected
// outputs queued and compared just after the following rising edge.
module tb_down_timer_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] load_val = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  count;
    logic [3:0]  done;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] lv;
        logic [3:0]  g;
        logic        b;
        logic [3:0]  c;
        logic [3:0]  d;
        int          id;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    down_timer_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [15:0] lv, input logic [3:0] g,
                       input logic b, input logic [3:0] c, input logic [3:0] d);
        vec_t v;
        v.req = r; v.lv = lv; v.g = g; v.b = b; v.c = c; v.d = d;
        v.id  = tbl.size();
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        req      = v.req;
        load_val = v.lv;
        sb.push_back(v);
    endtask

    // Scoreboard consumer: one expected record per rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            chk("grant", e.id, 32'(grant), 32'(e.g));
            chk("busy",  e.id, 32'(busy),  32'(e.b));
            chk("count", e.id, 32'(count), 32'(e.c));
            chk("done",  e.id, 32'(done),  32'(e.d));
        end
    end

    initial begin
        // Fairness: all requesting, load 1 each -> owners 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'(1) << (k % 4);
            add(4'hF, 16'h1111, oh,   1'b1, 4'd1, 4'h0);
            add(4'hF, 16'h1111, oh,   1'b1, 4'd0, 4'h0);
            add(4'hF, 16'h1111, oh,   1'b1, 4'd0, oh);
            add((k == 4) ? 4'h0 : 4'hF, 16'h1111, 4'h0, 1'b0, 4'd0, 4'h0);
        end
        // Requester 0, load 3: 3,2,1,0 then done on the 5th granted cycle.
        add(4'h1, 16'h0003, 4'h1, 1'b1, 4'd3, 4'h0);
        add(4'h1, 16'h0003, 4'h1, 1'b1, 4'd2, 4'h0);
        add(4'h1, 16'h0003, 4'h1, 1'b1, 4'd1, 4'h0);
        add(4'h1, 16'h0003, 4'h1, 1'b1, 4'd0, 4'h0);
        add(4'h1, 16'h0003, 4'h1, 1'b1, 4'd0, 4'h1);
        add(4'h0, 16'h0003, 4'h0, 1'b0, 4'd0, 4'h0);
        // Requester 2, load 0 (other slices 15): grant held 2 cycles.
        add(4'h4, 16'hF0FF, 4'h4, 1'b1, 4'd0, 4'h0);
        add(4'h4, 16'hF0FF, 4'h4, 1'b1, 4'd0, 4'h4);
        add(4'h0, 16'hF0FF, 4'h0, 1'b0, 4'd0, 4'h0);
        // Requester 1, load 9, abandoned at count 5: count holds, no done.
        add(4'h2, 16'h0090, 4'h2, 1'b1, 4'd9, 4'h0);
        add(4'h2, 16'h0090, 4'h2, 1'b1, 4'd8, 4'h0);
        add(4'h2, 16'h0090, 4'h2, 1'b1, 4'd7, 4'h0);
        add(4'h2, 16'h0090, 4'h2, 1'b1, 4'd6, 4'h0);
        add(4'h2, 16'h0090, 4'h2, 1'b1, 4'd5, 4'h0);
        add(4'h0, 16'h0090, 4'h0, 1'b0, 4'd5, 4'h0);
        add(4'h0, 16'h0090, 4'h0, 1'b0, 4'd5, 4'h0);
        // Then requester 0, load 2, served normally.
        add(4'h1, 16'h0002, 4'h1, 1'b1, 4'd2, 4'h0);
        add(4'h1, 16'h0002, 4'h1, 1'b1, 4'd1, 4'h0);
        add(4'h1, 16'h0002, 4'h1, 1'b1, 4'd0, 4'h0);
        add(4'h1, 16'h0002, 4'h1, 1'b1, 4'd0, 4'h1);
        add(4'h0, 16'h0002, 4'h0, 1'b0, 4'd0, 4'h0);
        // Requester 3, load 15: full range without wrap, done after 17 cycles.
        for (int v = 15; v >= 0; v--) begin
            add(4'h8, 16'hF000, 4'h8, 1'b1, 4'(v), 4'h0);
        end
        add(4'h8, 16'hF000, 4'h8, 1'b1, 4'd0, 4'h8);
        add(4'h0, 16'hF000, 4'h0, 1'b0, 4'd0, 4'h0);
        // Requester 3, load 9, run to count 7 before the async reset.
        add(4'h8, 16'h9000, 4'h8, 1'b1, 4'd9, 4'h0);
        add(4'h8, 16'h9000, 4'h8, 1'b1, 4'd8, 4'h0);
        add(4'h8, 16'h9000, 4'h8, 1'b1, 4'd7, 4'h0);

        // Reset state.
        #1;
        chk("rst_grant", -1, 32'(grant), 32'h0);
        chk("rst_busy",  -1, 32'(busy),  32'h0);
        chk("rst_count", -1, 32'(count), 32'h0);
        chk("rst_done",  -1, 32'(done),  32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end
        @(posedge clk);
        #2;
        chk("drain", -2, 32'(sb.size()), 32'h0);

        // Async reset mid-cycle at count 7: outputs clear without a clock edge.
        rst = 1'b1;
        #1;
        chk("arst_grant", -3, 32'(grant), 32'h0);
        chk("arst_busy",  -3, 32'(busy),  32'h0);
        chk("arst_count", -3, 32'(count), 32'h0);
        chk("arst_done",  -3, 32'(done),  32'h0);
        req      = 4'h0;
        load_val = 16'h1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // After reset, all requesting: requester 0 wins first; then abandon.
        tbl.delete();
        add(4'hF, 16'h1111, 4'h1, 1'b1, 4'd1, 4'h0);
        add(4'h0, 16'h1111, 4'h0, 1'b0, 4'd1, 4'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end
        @(posedge clk);
        #2;
        chk("drain2", -4, 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
